// File: rtl/seg_display_pkg.sv
// Shared types and constants for the 6-digit 7-segment time display driver.
package seg_display_pkg;

    // Conversion sweep states: snapshot, three BCD conversions, display load.
    typedef enum logic [2:0] {
        CAPTURE,
        CONV_SEC,
        CONV_MIN,
        CONV_HR,
        UPDATE
    } conv_state_t;

    localparam int DIGITS = 6;
    localparam int BCD_W  = 4;

    // Active-low gfedcba patterns for decimal digits 0..9.
    localparam logic [6:0] SEG_CODE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Non-decimal codes blank the digit rather than index past the table.
    function automatic logic [6:0] seg_encode(input logic [BCD_W-1:0] d);
        logic [6:0] code;
        code = 7'h7F;
        if (d <= 4'd9) begin
            code = SEG_CODE[d];
        end
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 7-bit binary to {hundreds, tens, ones} BCD.
// One load cycle on start, then seven shift/add-3 cycles; done pulses for
// one cycle once the result is valid and holds until the next start.
module bin2bcd_seq
    import seg_display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       bin,
    output logic [BCD_W-1:0] hundreds,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             done
);

    // {hundreds, tens, ones, binary} working register
    logic [18:0] sr_p0;
    logic [2:0]  cnt;
    logic        busy;

    // One double-dabble iteration: correct each BCD nibble, then shift left.
    function automatic logic [18:0] dabble_step(input logic [18:0] s);
        logic [18:0] r;
        r = s;
        if (r[10:7]  >= 4'd5) r[10:7]  = r[10:7]  + 4'd3;
        if (r[14:11] >= 4'd5) r[14:11] = r[14:11] + 4'd3;
        if (r[18:15] >= 4'd5) r[18:15] = r[18:15] + 4'd3;
        return {r[17:0], 1'b0};
    endfunction

    // Shift register datapath: load on start, iterate while busy.
    always_ff @(posedge clk) begin
        if (start) begin
            sr_p0 <= {12'd0, bin};
        end else if (busy) begin
            sr_p0 <= dabble_step(sr_p0);
        end
    end

    // Iteration counter and completion flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 3'd0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            cnt  <= 3'd7;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign hundreds = sr_p0[18:15];
    assign tens     = sr_p0[14:11];
    assign ones     = sr_p0[10:7];

endmodule

// File: rtl/seg_display_drv.sv
// Time display driver: snapshots sec/min/hr, converts them to BCD with one
// shared sequential converter in a 26-cycle sweep, and scans six
// common-anode 7-segment digits with active-low segments and anodes.
module seg_display_drv
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sec,
    input  logic [6:0] min,
    input  logic [4:0] hr,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       conv_busy,
    output logic       range_err
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    conv_state_t state, state_nxt;
    logic [2:0]  phase;

    logic [6:0]       snap_sec, snap_min, snap_hr;
    logic             start;
    logic [6:0]       conv_in;
    logic [BCD_W-1:0] bcd_h, bcd_t, bcd_o;
    logic             conv_done;
    logic             over;
    logic [BCD_W-1:0] clamp_t, clamp_o;

    logic [BCD_W-1:0] sec_t, sec_o, min_t, min_o;
    logic             sec_over, min_over;
    logic [BCD_W-1:0] disp [DIGITS];

    logic [DIV_W-1:0] div;
    logic [2:0]       idx, idx_nxt;

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (conv_in),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o),
        .done     (conv_done)
    );

    // Any nonzero hundreds digit means the field exceeded 99: show 99.
    assign over    = (bcd_h != 4'd0);
    assign clamp_t = over ? 4'd9 : bcd_t;
    assign clamp_o = over ? 4'd9 : bcd_o;

    // Sweep state register; phase counts cycles within the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CAPTURE;
            phase <= 3'd0;
        end else begin
            state <= state_nxt;
            phase <= (state_nxt != state) ? 3'd0 : phase + 3'd1;
        end
    end

    // Sweep sequencing: each conversion state starts the converter on its
    // first cycle and runs eight cycles in total.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        conv_in   = snap_hr;
        case (state)
            CAPTURE: state_nxt = CONV_SEC;
            CONV_SEC: begin
                conv_in = snap_sec;
                start   = (phase == 3'd0);
                if (phase == 3'd7) state_nxt = CONV_MIN;
            end
            CONV_MIN: begin
                conv_in = snap_min;
                start   = (phase == 3'd0);
                if (phase == 3'd7) state_nxt = CONV_HR;
            end
            CONV_HR: begin
                conv_in = snap_hr;
                start   = (phase == 3'd0);
                if (phase == 3'd7) state_nxt = UPDATE;
            end
            UPDATE:  state_nxt = CAPTURE;
            default: state_nxt = CAPTURE;
        endcase
    end

    assign conv_busy = (state != CAPTURE);

    // Snapshot the inputs once per sweep so the display is never mixed-time.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            snap_sec <= sec;
            snap_min <= min;
            snap_hr  <= {2'b00, hr};
        end
    end

    // Hold each finished field until the whole sweep is loaded at UPDATE;
    // a field's result is ready on the first cycle of the following state.
    always_ff @(posedge clk) begin
        if (conv_done && state == CONV_MIN) begin
            sec_t    <= clamp_t;
            sec_o    <= clamp_o;
            sec_over <= over;
        end
        if (conv_done && state == CONV_HR) begin
            min_t    <= clamp_t;
            min_o    <= clamp_o;
            min_over <= over;
        end
    end

    // Display registers and range flag load together at UPDATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) disp[i] <= '0;
            range_err <= 1'b0;
        end else if (state == UPDATE) begin
            disp[0]   <= sec_o;
            disp[1]   <= sec_t;
            disp[2]   <= min_o;
            disp[3]   <= min_t;
            disp[4]   <= clamp_o;
            disp[5]   <= clamp_t;
            range_err <= sec_over | min_over | over;
        end
    end

    assign idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;

    // Digit scan: the segment pattern is sampled only when a digit is
    // selected, so display updates never change a digit while it is lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= 3'd0;
            an  <= 6'b111110;
            seg <= SEG_CODE[0];
            dp  <= 1'b1;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= idx_nxt;
            an  <= ~(6'b000001 << idx_nxt);
            seg <= seg_encode(disp[idx_nxt]);
            dp  <= ~((idx_nxt == 3'd2) || (idx_nxt == 3'd4));
        end else begin
            div <= div + DIV_W'(1);
        end
    end

endmodule

// File: tb/tb_seg_display_drv.sv
// Randomized self-checking bench for seg_display_drv against a cycle-level
// reference model derived from the sweep and scan timing rules.
module tb_seg_display_drv;

    localparam int R     = 4;
    localparam int SWEEP = 26;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] sec, min;
    logic [4:0] hr;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       conv_busy, range_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         t;
    int         m_snap [3];
    int         m_disp [6];
    bit         m_err;
    logic [6:0] m_seg;
    logic       m_dp;

    seg_display_drv #(.REFRESH_DIV(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .sec       (sec),
        .min       (min),
        .hr        (hr),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .conv_busy (conv_busy),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_code(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;
            3: return 7'h30;  4: return 7'h19;  5: return 7'h12;
            6: return 7'h02;  7: return 7'h78;  8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 6; i++) m_disp[i] = 0;
        m_err = 1'b0;
        m_seg = 7'h40;
        m_dp  = 1'b1;
    endtask

    // Hold rst for n edges, checking reset outputs after each edge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_an", an, 6'b111110);
            check("rst_seg", seg, 7'h40);
            check("rst_dp", dp, 1'b1);
            check("rst_err", range_err, 1'b0);
            check("rst_busy", conv_busy, 1'b0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    // Check one cycle's outputs, then advance the model across the edge
    // that ends this cycle using the inputs currently applied.
    task automatic step();
        int         idx;
        int         v;
        logic [5:0] e_an;
        e_an = ~(6'b000001 << ((t / R) % 6));
        check("busy", conv_busy, ((t % SWEEP) != 0));
        check("an", an, e_an);
        check("seg", seg, m_seg);
        check("dp", dp, m_dp);
        check("range_err", range_err, m_err);

        if ((t % SWEEP) == 0) begin
            m_snap[0] = int'(sec);
            m_snap[1] = int'(min);
            m_snap[2] = int'(hr);
        end
        if (((t + 1) % R) == 0) begin
            idx   = ((t + 1) / R) % 6;
            m_seg = digit_code(m_disp[idx]);
            m_dp  = !(idx == 2 || idx == 4);
        end
        if ((t % SWEEP) == SWEEP - 1) begin
            m_err = 1'b0;
            for (int f = 0; f < 3; f++) begin
                v = m_snap[f];
                if (v > 99) begin
                    m_err = 1'b1;
                    v = 99;
                end
                m_disp[2*f]   = v % 10;
                m_disp[2*f+1] = v / 10;
            end
        end
        t++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_phase(input int ph);
        while ((t % SWEEP) != ph) step();
    endtask

    initial begin
        rst = 1'b1;
        sec = 7'd0;
        min = 7'd0;
        hr  = 5'd0;
        do_reset(3);

        // Fixed time, full sweep then full scans
        sec = 7'd45; min = 7'd27; hr = 5'd13;
        run(SWEEP + 6 * R * 2);

        // Out-of-range seconds, then recovery
        run_to_phase(SWEEP - 1);
        sec = 7'd100; min = 7'd5; hr = 5'd3;
        run(SWEEP * 2 + 6 * R);
        sec = 7'd59;
        run(SWEEP * 2 + 2);

        // Input change mid-sweep must wait for the next sweep
        run_to_phase(0);
        sec = 7'd10;
        run(10);
        sec = 7'd11;
        run(SWEEP * 3);

        // Reset during CONV_MIN with 12:34:56 on display
        sec = 7'd56; min = 7'd34; hr = 5'd12;
        run(SWEEP * 2 + 6 * R);
        run_to_phase(12);
        do_reset(1);
        check("post_rst_an", an, 6'b111110);
        check("post_rst_seg", seg, 7'h40);
        sec = 7'd7; min = 7'd8; hr = 5'd9;
        run(SWEEP * 2 + 6 * R);

        // Random values with random-time changes, including >99 fields
        for (int s = 0; s < 20; s++) begin
            sec = 7'($urandom_range(0, 127));
            min = 7'($urandom_range(0, 127));
            hr  = 5'($urandom_range(0, 31));
            for (int c = 0; c < SWEEP; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 2))
                        0: sec = 7'($urandom_range(0, 127));
                        1: min = 7'($urandom_range(0, 127));
                        default: hr = 5'($urandom_range(0, 31));
                    endcase
                end
                step();
            end
        end

        // Random reset at an arbitrary point, then recovery
        run($urandom_range(1, SWEEP));
        do_reset(2);
        run(SWEEP * 2 + 6 * R);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_display_drv.md
Name: seg_display_drv

Overview:
- Downstream consumer of the digital-clock counter outputs: sec[6:0], min[6:0], hr[4:0] in binary.
- Snapshots the three fields and converts each to two BCD digits with one shared sequential double-dabble converter.
- Drives a 6-digit, time-multiplexed, common-anode 7-segment display with a dp separator.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit (>=2); bench uses 4.

Ports:
- clk  in  1  system clock, the only clock
- rst  in  1  synchronous reset, active-high
- sec  in  7  seconds, binary
- min  in  7  minutes, binary
- hr  in  5  hours, binary
- seg  out  7  segments gfedcba, active-low
- dp  out  1  decimal point, active-low
- an  out  6  digit enables, active-low one-hot
- conv_busy  out  1  high while a conversion sweep is in progress
- range_err  out  1  a field of the last completed sweep was >99

Behaviour:
- Reset (rst=1 at a clk edge):
  - an=6'b111110, seg=7'h40 ('0'), dp=1, range_err=0, conv_busy=0.
  - Display registers cleared to 00:00:00; scan divider=0, digit idx=0; FSM in CAPTURE.
- Conversion FSM, free-running 26-cycle sweep:
  - CAPTURE (1 cycle): latch sec, min and hr (hr zero-extended to 7 bits) into a snapshot.
  - CONV_SEC, CONV_MIN, CONV_HR (8 cycles each): 1 load cycle plus 7 shift/add-3 cycles.
  - UPDATE (1 cycle): load all six display digits and range_err together, then return to CAPTURE.
- conv_busy timing:
  - conv_busy=0 in the first cycle after reset release; that cycle is the first CAPTURE.
  - conv_busy=1 in every other cycle, including UPDATE; it is 0 only in CAPTURE.
- Range handling:
  - A field value >99 displays as 99.
  - range_err is set at UPDATE if any snapshot field was >99; otherwise it is cleared at UPDATE.
- Snapshot isolation:
  - Input changes after CAPTURE never affect the sweep in progress; no mixed-time display.
  - New values appear at the UPDATE of the following sweep.
- Scan divider:
  - Counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 it wraps to 0 and idx advances (5 wraps to 0).
  - an, seg and dp are registered and load from the new idx in that same edge.
  - Each digit is lit for exactly REFRESH_DIV cycles.
- Digit map:
  - idx0 sec ones, idx1 sec tens, idx2 min ones, idx3 min tens, idx4 hr ones, idx5 hr tens.
  - dp=0 only at idx2 and idx4 (separators).
- Segment codes (active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex).
- Display update coherence: a display-register update mid-scan affects only digits lit afterwards.
- Reset mid-operation: rst in any state aborts the conversion and restores all reset values on the next edge; the partial conversion is discarded.

Decomposition:
- Package seg_display_pkg holds:
  - FSM state enum (CAPTURE, CONV_SEC, CONV_MIN, CONV_HR, UPDATE).
  - 10-entry segment-code constant table.
  - Digit-count constant 6 and BCD width 4.
- Sub-module bin2bcd_seq: start pulse, 7-bit binary in, 8 cycles to done.
  - Outputs {hundreds, tens, ones} BCD.
  - The top applies the >99 clamp using the hundreds digit.

Test Plan:
1. rst=1 for 3 cycles -> an=111110, seg=40, dp=1, range_err=0, conv_busy=0 in the cycle after release and 1 in the cycle after that.
2. sec=45, min=27, hr=13 held, REFRESH_DIV=4, run 26 cycles, then one full scan -> per-idx seg=12,19,78,24,30,79; dp=0 only at idx2 and idx4.
3. Scan timing with REFRESH_DIV=4 -> an steps 111110,111101,111011,110111,101111,011111 every 4 cycles and returns to 111110 at cycle 24.
4. sec=100, min=5, hr=3 -> after the first UPDATE sec digits show 9,9 (seg=10,10) and range_err=1; then sec=59 -> range_err=0 after the next UPDATE.
5. sec 10->11 changed 10 cycles after CAPTURE -> that sweep's UPDATE shows 10; the following sweep's UPDATE shows 11.
6. rst pulsed during CONV_MIN with the display holding 12:34:56 -> next edge: display 00:00:00, an=111110, seg=40, range_err=0; a new sweep starts on release.
